// File: rtl/c3_path_sweep_pkg.sv
// ---------------------------------------------------------------------------
// c3_path_sweep_pkg
// Shared types and widths for the c3_path exhaustive sweep controller.
//   VEC_W      : width of the stimulus vector index (nx1..nx4)
//   ERR_CNT_W  : width of the failing-vector counter (counts 0..16)
//   SETTLE_W   : width of the settle-cycle setting and its down-counter
//   sweep_state_e : controller FSM states
// ---------------------------------------------------------------------------
package c3_path_sweep_pkg;

    localparam int VEC_W     = 4;
    localparam int ERR_CNT_W = 5;
    localparam int SETTLE_W  = 4;

    localparam logic [VEC_W-1:0] LAST_VEC = {VEC_W{1'b1}};

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DRIVE   = 3'd1,
        ST_SETTLE  = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_DONE    = 3'd4
    } sweep_state_e;

    // States in which the current vector is presented on the drive pins.
    function automatic logic drives_vec(input sweep_state_e st);
        return (st == ST_DRIVE) || (st == ST_SETTLE) || (st == ST_CAPTURE);
    endfunction

endpackage

// File: rtl/c3_path_golden.sv
// ---------------------------------------------------------------------------
// c3_path_golden
// Combinational reference model of c3_path, used to form the expected
// outputs for the vector currently being applied.
//   v        : in  - vector index, v[0]=nx1 .. v[3]=nx4
//   exp_nx33 : out - expected nx33 = NOT nx3
//   exp_nx44 : out - expected nx44 = nx4
//   exp_nx12 : out - expected nx12 = NOT (nx1 AND nx2)
// ---------------------------------------------------------------------------
module c3_path_golden
    import c3_path_sweep_pkg::*;
(
    input  logic [VEC_W-1:0] v,
    output logic             exp_nx33,
    output logic             exp_nx44,
    output logic             exp_nx12
);

    logic nx1;
    logic nx2;
    logic nx3;
    logic nx4;

    assign nx1 = v[0];
    assign nx2 = v[1];
    assign nx3 = v[2];
    assign nx4 = v[3];

    assign exp_nx33 = ~nx3;
    assign exp_nx44 = nx4;
    assign exp_nx12 = ~(nx1 & nx2);

endmodule

// File: rtl/c3_path_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// c3_path_sweep_ctrl
// Drives all 16 input combinations into c3_path, waits a programmable
// settle time per vector, captures the three outputs and compares them
// against the golden model. Reports a mismatch count and the first
// failing vector.
//   clk           : in  - clock, rising edge
//   rst           : in  - synchronous active-high reset
//   start         : in  - sweep request, honoured only while idle
//   settle_cycles : in  - settle wait per vector, latched at start
//   drv_nx1..4    : out - registered stimulus to c3_path
//   cap_nx33/44/12: in  - c3_path outputs under test
//   busy          : out - high whenever not idle
//   done          : out - one-cycle pulse at end of sweep
//   err           : out - sticky mismatch flag
//   err_cnt       : out - number of failing vectors
//   err_vec       : out - index of first failing vector
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | waiting for start, drive pins low, results held
// ST_DRIVE   | first cycle of a vector on the drive pins
// ST_SETTLE  | down-counter running S cycles for c3_path to settle
// ST_CAPTURE | compare cap_* with golden outputs, advance vector
// ST_DONE    | single-cycle done pulse, drive pins low
// ---------------------------------------------------------------------------
module c3_path_sweep_ctrl
    import c3_path_sweep_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [SETTLE_W-1:0]  settle_cycles,
    output logic                 drv_nx1,
    output logic                 drv_nx2,
    output logic                 drv_nx3,
    output logic                 drv_nx4,
    input  logic                 cap_nx33,
    input  logic                 cap_nx44,
    input  logic                 cap_nx12,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic [VEC_W-1:0]     err_vec
);

    sweep_state_e         state_q,   state_d;
    logic [VEC_W-1:0]     vec_q,     vec_d;
    logic [SETTLE_W-1:0]  settle_q,  settle_d;
    logic [SETTLE_W-1:0]  cnt_q,     cnt_d;
    logic [VEC_W-1:0]     drv_q,     drv_d;
    logic                 busy_q,    busy_d;
    logic                 done_q,    done_d;
    logic                 err_q,     err_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [VEC_W-1:0]     err_vec_q, err_vec_d;

    logic exp_nx33;
    logic exp_nx44;
    logic exp_nx12;
    logic mismatch;

    c3_path_golden u_golden (
        .v        (vec_q),
        .exp_nx33 (exp_nx33),
        .exp_nx44 (exp_nx44),
        .exp_nx12 (exp_nx12)
    );

    assign mismatch = (cap_nx33 != exp_nx33) |
                      (cap_nx44 != exp_nx44) |
                      (cap_nx12 != exp_nx12);

    always_comb begin
        state_d   = state_q;
        vec_d     = vec_q;
        settle_d  = settle_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        err_cnt_d = err_cnt_q;
        err_vec_d = err_vec_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_DRIVE;
                    vec_d     = '0;
                    settle_d  = settle_cycles;
                    cnt_d     = '0;
                    err_d     = 1'b0;
                    err_cnt_d = '0;
                    err_vec_d = '0;
                end
            end

            ST_DRIVE: begin
                if (settle_q != '0) begin
                    state_d = ST_SETTLE;
                    cnt_d   = settle_q;
                end else begin
                    state_d = ST_CAPTURE;
                end
            end

            // Counter is loaded with S on entry; leaving when it reads 1
            // gives exactly S cycles in this state.
            ST_SETTLE: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == SETTLE_W'(1)) begin
                    state_d = ST_CAPTURE;
                end
            end

            ST_CAPTURE: begin
                if (mismatch) begin
                    err_d     = 1'b1;
                    err_cnt_d = err_cnt_q + 1'b1;
                    if (!err_q) begin
                        err_vec_d = vec_q;
                    end
                end
                if (vec_q == LAST_VEC) begin
                    state_d = ST_DONE;
                end else begin
                    vec_d   = vec_q + 1'b1;
                    state_d = ST_DRIVE;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs follow the next state so they are registered yet
        // line up with the state they describe.
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
        drv_d  = drives_vec(state_d) ? vec_d : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            vec_q     <= '0;
            settle_q  <= '0;
            cnt_q     <= '0;
            drv_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
            err_vec_q <= '0;
        end else begin
            state_q   <= state_d;
            vec_q     <= vec_d;
            settle_q  <= settle_d;
            cnt_q     <= cnt_d;
            drv_q     <= drv_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
            err_vec_q <= err_vec_d;
        end
    end

    assign drv_nx1 = drv_q[0];
    assign drv_nx2 = drv_q[1];
    assign drv_nx3 = drv_q[2];
    assign drv_nx4 = drv_q[3];
    assign busy    = busy_q;
    assign done    = done_q;
    assign err     = err_q;
    assign err_cnt = err_cnt_q;
    assign err_vec = err_vec_q;

endmodule

// File: tb/tb_c3_path_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// tb_c3_path_sweep_ctrl
// Bench for the c3_path sweep controller. A behavioural c3_path with
// selectable faults answers the drive pins; a sweep-level model predicts
// timing, the vector sequence and the error summary.
// ---------------------------------------------------------------------------
module tb_c3_path_sweep_ctrl;

    localparam int M_GOOD   = 0;
    localparam int M_STUCK  = 1;   // nx12 stuck at 1
    localparam int M_INV44  = 2;   // nx44 inverted
    localparam int M_RANDOM = 3;   // per-vector random bit flips

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] settle_cycles;
    logic       drv_nx1, drv_nx2, drv_nx3, drv_nx4;
    logic       cap_nx33, cap_nx44, cap_nx12;
    logic       busy, done, err;
    logic [4:0] err_cnt;
    logic [3:0] err_vec;

    int         checks = 0;
    int         errors = 0;
    int         fault_mode = M_GOOD;
    logic [2:0] flip_tbl [16];
    logic [3:0] drv_vec;

    always #5 clk = ~clk;

    c3_path_sweep_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .settle_cycles (settle_cycles),
        .drv_nx1       (drv_nx1),
        .drv_nx2       (drv_nx2),
        .drv_nx3       (drv_nx3),
        .drv_nx4       (drv_nx4),
        .cap_nx33      (cap_nx33),
        .cap_nx44      (cap_nx44),
        .cap_nx12      (cap_nx12),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .err_cnt       (err_cnt),
        .err_vec       (err_vec)
    );

    // {nx33, nx44, nx12} of a healthy c3_path for vector index v
    function automatic logic [2:0] golden(input int v);
        int nx1, nx2, nx3, nx4;
        nx1 = v % 2;
        nx2 = (v / 2) % 2;
        nx3 = (v / 4) % 2;
        nx4 = (v / 8) % 2;
        return {logic'(nx3 == 0), logic'(nx4 == 1), logic'(!(nx1 == 1 && nx2 == 1))};
    endfunction

    function automatic logic [2:0] path_out(input int v, input int mode, input logic [2:0] flip);
        logic [2:0] o;
        o = golden(v);
        case (mode)
            M_STUCK:  o[0] = 1'b1;
            M_INV44:  o[1] = ~o[1];
            M_RANDOM: o    = o ^ flip;
            default:  ;
        endcase
        return o;
    endfunction

    assign drv_vec = {drv_nx4, drv_nx3, drv_nx2, drv_nx1};
    assign {cap_nx33, cap_nx44, cap_nx12} = path_out(int'(drv_vec), fault_mode, flip_tbl[drv_vec]);

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_quiet(input string tag);
        check_eq({tag, "_busy"}, 32'(busy), 0);
        check_eq({tag, "_done"}, 32'(done), 0);
        check_eq({tag, "_drv"},  32'(drv_vec), 0);
    endtask

    // Issue start with settle value s; returns just after the accepting edge.
    task automatic issue_start(input int s);
        @(negedge clk);
        start         = 1'b1;
        settle_cycles = 4'(s);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // One full sweep checked cycle by cycle. With disturb set, start is
    // re-pulsed and settle_cycles scrambled while vector 6 is applied.
    task automatic run_sweep(input int s, input int mode, input bit disturb);
        int period, total, exp_cnt, exp_vec;
        bit seen;
        period  = s + 2;
        total   = 16 * period;
        exp_cnt = 0;
        exp_vec = 0;
        seen    = 0;
        fault_mode = mode;
        for (int v = 0; v < 16; v++) begin
            if (path_out(v, mode, flip_tbl[v]) != golden(v)) begin
                exp_cnt++;
                if (!seen) begin
                    exp_vec = v;
                    seen    = 1;
                end
            end
        end

        issue_start(s);
        for (int t = 1; t <= total + 2; t++) begin
            int v;
            @(negedge clk);
            v = (t - 1) / period;
            if (t <= total) begin
                check_eq("sw_busy", 32'(busy), 1);
                check_eq("sw_done", 32'(done), 0);
                check_eq("sw_drv",  32'(drv_vec), 32'(v));
            end else if (t == total + 1) begin
                check_eq("end_done", 32'(done), 1);
                check_eq("end_busy", 32'(busy), 1);
                check_eq("end_drv",  32'(drv_vec), 0);
            end else begin
                check_quiet("idle");
                check_eq("res_err",  32'(err),     32'(exp_cnt != 0));
                check_eq("res_cnt",  32'(err_cnt), 32'(exp_cnt));
                check_eq("res_vec",  32'(err_vec), 32'(exp_vec));
            end
            if (disturb) begin
                if (t <= total && v == 6) begin
                    start         = ((t - 1) % period == 0) ? 1'b1 : 1'($urandom_range(0, 1));
                    settle_cycles = 4'($urandom);
                end else begin
                    start = 1'b0;
                end
            end
        end

        repeat (3) @(negedge clk);
        check_quiet("hold");
        check_eq("hold_err", 32'(err),     32'(exp_cnt != 0));
        check_eq("hold_cnt", 32'(err_cnt), 32'(exp_cnt));
        check_eq("hold_vec", 32'(err_vec), 32'(exp_vec));
    endtask

    // Reset while vector 5 is settling, then verify everything is cleared.
    task automatic reset_mid_sweep(input int s);
        int period;
        bool_loop: begin
        end
        period     = s + 2;
        fault_mode = M_INV44;
        issue_start(s);
        for (int t = 1; t <= 16 * period; t++) begin
            @(negedge clk);
            if ((t - 1) / period == 5 && (t - 1) % period == 1) begin
                check_eq("pre_rst_err", 32'(err), 1);
                rst = 1'b1;
                break;
            end
        end
        @(negedge clk);
        rst = 1'b0;
        check_quiet("rst");
        check_eq("rst_err", 32'(err),     0);
        check_eq("rst_cnt", 32'(err_cnt), 0);
        check_eq("rst_vec", 32'(err_vec), 0);
        @(negedge clk);
        check_quiet("rst_idle");
    endtask

    initial begin
        rst           = 1'b1;
        start         = 1'b0;
        settle_cycles = 4'd0;
        for (int i = 0; i < 16; i++) flip_tbl[i] = 3'b0;
        repeat (3) @(negedge clk);
        check_quiet("por");
        check_eq("por_err", 32'(err),     0);
        check_eq("por_cnt", 32'(err_cnt), 0);
        check_eq("por_vec", 32'(err_vec), 0);
        rst = 1'b0;

        run_sweep(2, M_GOOD, 1'b0);
        run_sweep(0, M_STUCK, 1'b0);
        run_sweep(int'($urandom_range(0, 3)), M_INV44, 1'b0);
        run_sweep(3, M_GOOD, 1'b1);

        for (int n = 0; n < 5; n++) begin
            for (int i = 0; i < 16; i++)
                flip_tbl[i] = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'b0;
            run_sweep(int'($urandom_range(0, 5)), M_RANDOM, n[0]);
        end

        // leave stale errors behind, then reset mid-sweep and restart clean
        run_sweep(1, M_STUCK, 1'b0);
        reset_mid_sweep(int'($urandom_range(1, 4)));
        run_sweep(1, M_GOOD, 1'b0);

        // rst wins over start in the same cycle
        @(negedge clk);
        rst   = 1'b1;
        start = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        check_quiet("rst_start");
        @(negedge clk);
        check_quiet("rst_start_idle");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
